// File: rtl/frame_wr_addr_pkg.sv
// rtl/frame_wr_addr_pkg.sv - shared OV7670 frame-buffer constants and write FSM encoding
//
// Purpose : constants shared between the frame-buffer write and read address
//           generators so both ends agree on frame size and state encoding.
// Contents: wr_state_t (WR_IDLE, WR_CAPTURE, WR_DONE), WR_PIXELS_DEF (160x120),
//           HIGH / LOW / ZERO constants.
package frame_wr_addr_pkg;

    localparam int WR_PIXELS_DEF = 19200;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;
    localparam int   ZERO = 0;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_CAPTURE = 2'd1,
        WR_DONE    = 2'd2
    } wr_state_t;

endpackage

// File: rtl/frame_wr_addr_vsync_edge_det.sv
// rtl/frame_wr_addr_vsync_edge_det.sv - registered rising-edge detector for camera sync lines
//
// Purpose : keeps a one-cycle delayed copy of sig_i and flags sig_i & ~delayed.
//           The delay register updates every cycle regardless of the consumer's state.
// Ports   : clk_i   in  clock
//           reset_i in  synchronous reset, active-high
//           sig_i   in  level input, already synchronous to clk_i
//           rise_o  out high in the cycle sig_i is 1 and was 0 last cycle
module vsync_edge_det
    import frame_wr_addr_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_d_q;
    logic sig_d_d;

    always_comb begin
        sig_d_d = sig_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sig_d_q <= LOW;
        end else begin
            sig_d_q <= sig_d_d;
        end
    end

    assign rise_o = sig_i & ~sig_d_q;

endmodule

// File: rtl/frame_wr_addr.sv
// rtl/frame_wr_addr.sv - OV7670 frame-buffer write-address generator
//
// Purpose : captures one frame of assembled pixels into BRAM starting at the
//           VSYNC rising edge, raises Frame_Available_o and holds the buffer
//           until the reader acknowledges with Mem_Ack_i.
// Ports   : Clk_i, Reset_i (sync, active-high), Vsync_i, Pixel_Valid_i,
//           Pixel_Data_i, Mem_Ack_i in; Wr_En_o, Wr_Addr_o, Wr_Data_o,
//           Frame_Available_o out; Frame_Drop_Cnt_o out when
//           FRAME_WR_DROP_CNT_EN is defined (counts frames dropped in DONE).
module frame_wr_addr
    import frame_wr_addr_pkg::*;
#(
    parameter int ADDR_W_P = 15,
    parameter int DATA_W_P = 8,
    parameter int PIXELS_P = WR_PIXELS_DEF
) (
    input  logic                Clk_i,
    input  logic                Reset_i,
    input  logic                Vsync_i,
    input  logic                Pixel_Valid_i,
    input  logic [DATA_W_P-1:0] Pixel_Data_i,
    input  logic                Mem_Ack_i,
    output logic                Wr_En_o,
    output logic [ADDR_W_P-1:0] Wr_Addr_o,
    output logic [DATA_W_P-1:0] Wr_Data_o,
`ifdef FRAME_WR_DROP_CNT_EN
    output logic [7:0]          Frame_Drop_Cnt_o,
`endif
    output logic                Frame_Available_o
);

    localparam int CNT_W = ADDR_W_P + 1;
    localparam logic [CNT_W-1:0] PIX_CNT  = CNT_W'(PIXELS_P);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIXELS_P - 1);

    wr_state_t             state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_W_P-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W_P-1:0]   wr_data_q, wr_data_d;
    logic                  frame_avail_q, frame_avail_d;
    logic [CNT_W-1:0]      wr_idx;
    logic                  vs_rise;

    vsync_edge_det u_vsync_edge_det (
        .clk_i   (Clk_i),
        .reset_i (Reset_i),
        .sig_i   (Vsync_i),
        .rise_o  (vs_rise)
    );

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        wr_en_d       = LOW;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_avail_d = frame_avail_q;
        // A VSYNC edge mid-capture restarts the frame; a coincident pixel lands at 0.
        wr_idx        = vs_rise ? '0 : count_q;

        case (state_q)
            WR_IDLE: begin
                count_d       = '0;
                frame_avail_d = LOW;
                if (vs_rise) begin
                    state_d = WR_CAPTURE;
                end
            end
            WR_CAPTURE: begin
                frame_avail_d = LOW;
                if (Pixel_Valid_i && (wr_idx < PIX_CNT)) begin
                    wr_en_d   = HIGH;
                    wr_addr_d = wr_idx[ADDR_W_P-1:0];
                    wr_data_d = Pixel_Data_i;
                    count_d   = wr_idx + CNT_W'(1);
                    if (wr_idx == LAST_CNT) begin
                        state_d = WR_DONE;
                    end
                end else if (vs_rise) begin
                    count_d = '0;
                end
            end
            WR_DONE: begin
                // Buffer owned by the reader: pixels and VSYNC edges are dropped.
                frame_avail_d = HIGH;
                if (Mem_Ack_i) begin
                    frame_avail_d = LOW;
                    state_d       = WR_IDLE;
                end
            end
            default: begin
                state_d       = WR_IDLE;
                count_d       = '0;
                wr_addr_d     = '0;
                wr_data_d     = '0;
                frame_avail_d = LOW;
            end
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q       <= WR_IDLE;
            count_q       <= '0;
            wr_en_q       <= LOW;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_avail_q <= LOW;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_avail_q <= frame_avail_d;
        end
    end

`ifdef FRAME_WR_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if ((state_q == WR_DONE) && vs_rise && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign Frame_Drop_Cnt_o = drop_cnt_q;
`endif

    assign Wr_En_o           = wr_en_q;
    assign Wr_Addr_o         = wr_addr_q;
    assign Wr_Data_o         = wr_data_q;
    assign Frame_Available_o = frame_avail_q;

endmodule

// File: tb/tb_frame_wr_addr.sv
// tb/tb_frame_wr_addr.sv - self-checking bench for frame_wr_addr
module tb_frame_wr_addr;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int PIXELS = 19200;

    logic              clk;
    logic              rst;
    logic              vsync;
    logic              pv;
    logic [DATA_W-1:0] pd;
    logic              ack;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              fa;
`ifdef FRAME_WR_DROP_CNT_EN
    logic [7:0]        drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    frame_wr_addr #(
        .ADDR_W_P (ADDR_W),
        .DATA_W_P (DATA_W),
        .PIXELS_P (PIXELS)
    ) dut (
        .Clk_i             (clk),
        .Reset_i           (rst),
        .Vsync_i           (vsync),
        .Pixel_Valid_i     (pv),
        .Pixel_Data_i      (pd),
        .Mem_Ack_i         (ack),
        .Wr_En_o           (wr_en),
        .Wr_Addr_o         (wr_addr),
        .Wr_Data_o         (wr_data),
`ifdef FRAME_WR_DROP_CNT_EN
        .Frame_Drop_Cnt_o  (drop_cnt),
`endif
        .Frame_Available_o (fa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // One-cycle VSYNC pulse without a pixel; returns with Vsync low again.
    task automatic vsync_pulse();
        vsync = 1'b1;
        pv    = 1'b0;
        step();
        vsync = 1'b0;
    endtask

    // Back-to-back strobes; each write must appear one cycle later at the
    // model address start+i with the driven data, frame not yet available.
    task automatic run_pixels(input int n, input int start, input bit data_is_addr);
        logic [DATA_W-1:0] d;
        int                a;
        for (int i = 0; i < n; i++) begin
            a  = start + i;
            d  = data_is_addr ? DATA_W'(a) : DATA_W'($urandom);
            pv = 1'b1;
            pd = d;
            step();
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(a) || wr_data !== d || fa !== 1'b0) begin
                failures++;
                $display("FAIL write[%0d]: en=%b addr=%0d data=%02h fa=%b, want en=1 addr=%0d data=%02h fa=0",
                         a, wr_en, wr_addr, wr_data, fa, a, d);
            end
        end
        pv = 1'b0;
    endtask

    task automatic expect_frame_ready(input string name, input int last_addr);
        step();
        checks++;
        if (fa !== 1'b1 || wr_en !== 1'b0 || wr_addr !== ADDR_W'(last_addr)) begin
            failures++;
            $display("FAIL %s: fa=%b en=%b addr=%0d, want fa=1 en=0 addr=%0d",
                     name, fa, wr_en, wr_addr, last_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b0; pv = 1'b0; pd = '0; ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || fa !== 1'b0) begin
            failures++;
            $display("FAIL reset: en=%b addr=%0d data=%02h fa=%b, want all 0", wr_en, wr_addr, wr_data, fa);
        end
`ifdef FRAME_WR_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt);
        end
`endif
        // No VSYNC edge yet: strobes must not write.
        pv = 1'b1; pd = 8'h5A;
        step();
        pv = 1'b0;
        checks++;
        if (wr_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_write: en=%b want 0", wr_en);
        end
    endtask

    task automatic test_full_frame();
        vsync_pulse();
        run_pixels(PIXELS, 0, 1'b1);
        checks++;
        if (fa !== 1'b0) begin
            failures++;
            $display("FAIL fa_on_last_write: fa=%b want 0", fa);
        end
        expect_frame_ready("full_frame_ready", PIXELS - 1);
    endtask

    task automatic test_done_ignore();
        vsync_pulse();
        for (int i = 0; i < 10; i++) begin
            pv = 1'b1;
            pd = DATA_W'($urandom);
            step();
            checks++;
            if (wr_en !== 1'b0 || fa !== 1'b1) begin
                failures++;
                $display("FAIL done_ignore[%0d]: en=%b fa=%b, want en=0 fa=1", i, wr_en, fa);
            end
        end
        pv = 1'b0;
`ifdef FRAME_WR_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd1) begin
            failures++;
            $display("FAIL drop_cnt_done: got %0d want 1", drop_cnt);
        end
`endif
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if (fa !== 1'b0) begin
            failures++;
            $display("FAIL ack_release: fa=%b want 0", fa);
        end
        pv = 1'b1; pd = DATA_W'($urandom);
        step();
        pv = 1'b0;
        checks++;
        if (wr_en !== 1'b0) begin
            failures++;
            $display("FAIL after_ack_idle: en=%b want 0", wr_en);
        end
    endtask

    task automatic test_short_frame();
        logic [DATA_W-1:0] d;
        vsync_pulse();
        run_pixels(500, 0, 1'b0);
        // Restart edge with a coincident pixel: that pixel lands at address 0.
        d     = DATA_W'($urandom);
        vsync = 1'b1;
        pv    = 1'b1;
        pd    = d;
        step();
        vsync = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== d || fa !== 1'b0) begin
            failures++;
            $display("FAIL restart_write: en=%b addr=%0d data=%02h fa=%b, want en=1 addr=0 data=%02h fa=0",
                     wr_en, wr_addr, wr_data, fa, d);
        end
        run_pixels(PIXELS - 1, 1, 1'b0);
        expect_frame_ready("short_frame_ready", PIXELS - 1);
    endtask

    task automatic test_ack_with_vsync();
        ack   = 1'b1;
        vsync = 1'b1;
        step();
        ack   = 1'b0;
        vsync = 1'b0;
        checks++;
        if (fa !== 1'b0) begin
            failures++;
            $display("FAIL ack_vsync_release: fa=%b want 0", fa);
        end
`ifdef FRAME_WR_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd2) begin
            failures++;
            $display("FAIL drop_cnt_ack_vsync: got %0d want 2", drop_cnt);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            pv = 1'b1;
            pd = DATA_W'($urandom);
            step();
            checks++;
            if (wr_en !== 1'b0) begin
                failures++;
                $display("FAIL lost_frame_no_write[%0d]: en=%b want 0", i, wr_en);
            end
        end
        pv = 1'b0;
        vsync_pulse();
        run_pixels(5, 0, 1'b0);
    endtask

    task automatic test_reset_mid_capture();
        vsync_pulse();
        run_pixels(9000, 0, 1'b0);
        rst = 1'b1;
        pv  = 1'b1;
        pd  = DATA_W'($urandom);
        step();
        rst = 1'b0;
        pv  = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || fa !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: en=%b addr=%0d data=%02h fa=%b, want all 0", wr_en, wr_addr, wr_data, fa);
        end
`ifdef FRAME_WR_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid_drop_cnt: got %0d want 0", drop_cnt);
        end
`endif
        pv = 1'b1; pd = DATA_W'($urandom);
        step();
        pv = 1'b0;
        checks++;
        if (wr_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle: en=%b want 0", wr_en);
        end
        vsync_pulse();
        run_pixels(3, 0, 1'b0);
    endtask

    task automatic test_gapped();
        logic [DATA_W-1:0] d;
        vsync_pulse();
        for (int i = 0; i < 200; i++) begin
            d  = DATA_W'($urandom);
            pv = 1'b1;
            pd = d;
            step();
            pv = 1'b0;
            pd = DATA_W'($urandom);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(i) || wr_data !== d) begin
                failures++;
                $display("FAIL gapped_write[%0d]: en=%b addr=%0d data=%02h, want en=1 addr=%0d data=%02h",
                         i, wr_en, wr_addr, wr_data, i, d);
            end
            for (int g = 0; g < 2; g++) begin
                step();
                checks++;
                if (wr_en !== 1'b0 || wr_addr !== ADDR_W'(i) || wr_data !== d) begin
                    failures++;
                    $display("FAIL gapped_hold[%0d.%0d]: en=%b addr=%0d data=%02h, want en=0 addr=%0d data=%02h",
                             i, g, wr_en, wr_addr, wr_data, i, d);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_done_ignore();
        test_short_frame();
        test_ack_with_vsync();
        test_reset_mid_capture();
        test_gapped();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
